// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters
// (pipeline port P, loader/debug port E) and the single-ported data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Port P (pipeline memory stage)
    logic              p_req;
    logic              p_rw;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_stall;
    logic              p_ack;
    logic [DATA_W-1:0] p_rdata;

    // Port E (external loader/debug)
    logic              e_req;
    logic              e_rw;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_ack;
    logic [DATA_W-1:0] e_rdata;

    // Memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_dout;

    logic              busy;

    // Arbiter view
    modport slave (
        input  p_req, p_rw, p_addr, p_wdata,
        input  e_req, e_rw, e_addr, e_wdata,
        input  mem_dout,
        output p_stall, p_ack, p_rdata,
        output e_ack, e_rdata,
        output mem_addr, mem_din, mem_rw,
        output busy
    );

    // Requesters plus memory view
    modport master (
        output p_req, p_rw, p_addr, p_wdata,
        output e_req, e_rw, e_addr, e_wdata,
        output mem_dout,
        input  p_stall, p_ack, p_rdata,
        input  e_ack, e_rdata,
        input  mem_addr, mem_din, mem_rw,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the pipeline (P) and the
// loader/debug port (E): one grant per cycle, round-robin with a bounded
// burst, ack and read data one cycle after the grant.
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_E = 1'b1
    } owner_t;

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [3:0] BURST_SAT   = 4'd15;

    owner_t     last_owner_q, last_owner_d;
    logic [3:0] burst_cnt_q,  burst_cnt_d;
    logic       ack_p_q, ack_p_d;
    logic       ack_e_q, ack_e_d;
    logic       rd_p_q,  rd_p_d;
    logic       rd_e_q,  rd_e_d;

    logic gnt_p;
    logic gnt_e;
    logic owner_prev_granted;

    function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
        return (cnt == BURST_SAT) ? BURST_SAT : cnt + 4'd1;
    endfunction

    // Arbitration state; reset leaves E as last owner so P wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_E;
            burst_cnt_q  <= 4'd0;
            ack_p_q      <= 1'b0;
            ack_e_q      <= 1'b0;
            rd_p_q       <= 1'b0;
            rd_e_q       <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            ack_p_q      <= ack_p_d;
            ack_e_q      <= ack_e_d;
            rd_p_q       <= rd_p_d;
            rd_e_q       <= rd_e_d;
        end
    end

    // Grant decision; the last owner keeps a tie only while its burst is running
    always_comb begin
        gnt_p = 1'b0;
        gnt_e = 1'b0;
        owner_prev_granted = (last_owner_q == OWN_P) ? ack_p_q : ack_e_q;
        if (rst) begin
            if (bus.p_req && bus.e_req) begin
                if (owner_prev_granted && (burst_cnt_q < MAX_BURST_C)) begin
                    gnt_p = (last_owner_q == OWN_P);
                    gnt_e = (last_owner_q == OWN_E);
                end else begin
                    gnt_p = (last_owner_q == OWN_E);
                    gnt_e = (last_owner_q == OWN_P);
                end
            end else begin
                gnt_p = bus.p_req;
                gnt_e = bus.e_req;
            end
        end
    end

    // Next state: owner, burst length, and the one-cycle ack/read pipeline
    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = 4'd0;
        ack_p_d      = gnt_p;
        ack_e_d      = gnt_e;
        rd_p_d       = gnt_p & ~bus.p_rw;
        rd_e_d       = gnt_e & ~bus.e_rw;
        if (gnt_p) begin
            last_owner_d = OWN_P;
            burst_cnt_d  = ack_p_q ? burst_inc(burst_cnt_q) : 4'd1;
        end else if (gnt_e) begin
            last_owner_d = OWN_E;
            burst_cnt_d  = ack_e_q ? burst_inc(burst_cnt_q) : 4'd1;
        end
    end

    // Memory bus mux and requester-facing outputs
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_rw   = 1'b0;
        if (gnt_p) begin
            bus.mem_addr = bus.p_addr;
            bus.mem_din  = bus.p_wdata;
            bus.mem_rw   = bus.p_rw;
        end else if (gnt_e) begin
            bus.mem_addr = bus.e_addr;
            bus.mem_din  = bus.e_wdata;
            bus.mem_rw   = bus.e_rw;
        end
        bus.p_stall = rst & bus.p_req & ~gnt_p;
        bus.p_ack   = ack_p_q;
        bus.e_ack   = ack_e_q;
        bus.p_rdata = (ack_p_q && rd_p_q) ? bus.mem_dout : '0;
        bus.e_rdata = (ack_e_q && rd_e_q) ? bus.mem_dout : '0;
        bus.busy    = gnt_p | gnt_e | ack_p_q | ack_e_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a run-length arbitration model and a
// reference memory image.
module tb_dmem_arbiter;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-ported synchronous memory seen by the arbiter
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner of the current run and its length
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int m_last;            // 0 = P, 1 = E
    int m_prev;            // port granted last cycle, -1 if none
    int m_run;             // length of the current grant run
    int m_win;             // port granted in the most recent step, -1 if none
    logic m_ackp, m_acke;
    logic [DATA_W-1:0] m_rdp, m_rde;

    task automatic model_reset();
        m_last = 1;
        m_prev = -1;
        m_run  = 0;
        m_win  = -1;
        m_ackp = 1'b0;
        m_acke = 1'b0;
        m_rdp  = '0;
        m_rde  = '0;
    endtask

    task automatic step(input logic pr, input logic prw, input logic [ADDR_W-1:0] pa,
                        input logic [DATA_W-1:0] pd,
                        input logic er, input logic erw, input logic [ADDR_W-1:0] ea,
                        input logic [DATA_W-1:0] ed);
        logic [ADDR_W-1:0] xa;
        logic [DATA_W-1:0] xd;
        logic xrw;
        @(negedge clk);
        bus.p_req = pr; bus.p_rw = prw; bus.p_addr = pa; bus.p_wdata = pd;
        bus.e_req = er; bus.e_rw = erw; bus.e_addr = ea; bus.e_wdata = ed;
        #1;
        if (pr && er)
            m_win = (m_prev >= 0 && m_run < MAX_BURST) ? m_prev : 1 - m_last;
        else if (pr) m_win = 0;
        else if (er) m_win = 1;
        else         m_win = -1;
        xa  = (m_win == 0) ? pa  : (m_win == 1) ? ea  : '0;
        xd  = (m_win == 0) ? pd  : (m_win == 1) ? ed  : '0;
        xrw = (m_win == 0) ? prw : (m_win == 1) ? erw : 1'b0;
        chk("mem_addr", 64'(bus.mem_addr), 64'(xa));
        chk("mem_din",  64'(bus.mem_din),  64'(xd));
        chk("mem_rw",   64'(bus.mem_rw),   64'(xrw));
        chk("p_stall",  64'(bus.p_stall),  64'(pr && m_win != 0));
        chk("p_ack",    64'(bus.p_ack),    64'(m_ackp));
        chk("e_ack",    64'(bus.e_ack),    64'(m_acke));
        chk("p_rdata",  64'(bus.p_rdata),  64'(m_rdp));
        chk("e_rdata",  64'(bus.e_rdata),  64'(m_rde));
        chk("busy",     64'(bus.busy),     64'(m_win >= 0 || m_ackp || m_acke));
        m_ackp = (m_win == 0);
        m_acke = (m_win == 1);
        m_rdp  = (m_win == 0 && !xrw) ? ref_mem[xa] : '0;
        m_rde  = (m_win == 1 && !xrw) ? ref_mem[xa] : '0;
        if (m_win >= 0 && xrw) ref_mem[xa] = xd;
        if (m_win < 0) begin
            m_prev = -1;
            m_run  = 0;
        end else begin
            m_run  = (m_win == m_prev) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
            m_prev = m_win;
            m_last = m_win;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    logic              pr, prw, er, erw;
    logic [ADDR_W-1:0] pa, ea;
    logic [DATA_W-1:0] pd, ed;
    int                p_wait;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mem[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        bus.p_req = 1'b1; bus.p_rw = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.e_req = 1'b1; bus.e_rw = 1'b0; bus.e_addr = '0; bus.e_wdata = '0;
        model_reset();
        #1 rst = 1'b0;

        // Reset held with both ports requesting: everything quiet
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_din",  64'(bus.mem_din),  64'd0);
        chk("rst_mem_rw",   64'(bus.mem_rw),   64'd0);
        chk("rst_p_stall",  64'(bus.p_stall),  64'd0);
        chk("rst_p_ack",    64'(bus.p_ack),    64'd0);
        chk("rst_e_ack",    64'(bus.e_ack),    64'd0);
        chk("rst_p_rdata",  64'(bus.p_rdata),  64'd0);
        chk("rst_e_rdata",  64'(bus.e_rdata),  64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        bus.p_req = 1'b0;
        bus.e_req = 1'b0;
        rst = 1'b1;

        // Continuous contention from reset: P x MAX_BURST, then E x MAX_BURST, ...
        for (int i = 0; i < 4 * MAX_BURST; i++) begin
            step(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 1'b0, ADDR_W'(i + 100), '0);
            chk("contention_pat", 64'(bus.p_stall), 64'((i / MAX_BURST) % 2));
        end
        idle();

        // Single P read of a preloaded word
        step(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        chk("rd5_addr", 64'(bus.mem_addr), 64'h5);
        idle();
        chk("rd5_data", 64'(bus.p_rdata), 64'hDEADBEEF);

        // Write then read the top address back-to-back
        step(1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 10'h3FF, '0, 1'b0, 1'b0, '0, '0);
        chk("wr_ack_rdata", 64'(bus.p_rdata), 64'd0);
        idle();
        chk("raw_data", 64'(bus.p_rdata), 64'h12345678);

        // E alone, then P joins and must get in within the burst bound
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, ADDR_W'(i + 32), DATA_W'(i * 3 + 7));
        p_wait = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, ADDR_W'(32 + i), '0, 1'b1, 1'b0, ADDR_W'(40), '0);
            if (bus.p_stall) p_wait++;
        end
        chk("p_join_wait", 64'(p_wait <= MAX_BURST), 64'd1);
        idle();

        // Reset asserted inside a grant cycle drops the pending ack
        step(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_p_ack", 64'(bus.p_ack), 64'd0);
        chk("midrst_busy",  64'(bus.busy),  64'd0);
        @(negedge clk);
        bus.p_req = 1'b0;
        bus.e_req = 1'b0;
        rst = 1'b1;
        step(1'b1, 1'b0, 10'h006, '0, 1'b1, 1'b0, 10'h007, '0);
        chk("post_rst_p_first", 64'(bus.p_stall), 64'd0);
        idle();

        // Randomized traffic; a denied request holds its fields until granted
        pr = 1'b0; er = 1'b0; prw = 1'b0; erw = 1'b0;
        pa = '0; ea = '0; pd = '0; ed = '0;
        p_wait = 0;
        m_win = -1;
        for (int i = 0; i < 1500; i++) begin
            if (!(pr && m_win != 0)) begin
                pr  = ($urandom_range(0, 3) != 0);
                prw = 1'($urandom_range(0, 1));
                pa  = ADDR_W'($urandom_range(0, 15));
                pd  = DATA_W'($urandom);
            end
            if (!(er && m_win != 1)) begin
                er  = ($urandom_range(0, 3) != 0);
                erw = 1'($urandom_range(0, 1));
                ea  = ADDR_W'($urandom_range(0, 15));
                ed  = DATA_W'($urandom);
            end
            step(pr, prw, pa, pd, er, erw, ea, ed);
            p_wait = bus.p_stall ? p_wait + 1 : 0;
            chk("p_wait_bound", 64'(p_wait <= MAX_BURST), 64'd1);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
